// File: rtl/y86_prefetch_fetch.sv
// y86_prefetch_fetch: sequential Y86-64 fetch stage with a circular byte
// prefetch buffer. It fills the buffer from instruction memory over a
// req/ack port, finds the length of the instruction at the head, and hands
// the decoded fields to decode over valid/ready. It supports redirect/flush
// and halts after presenting an out-of-memory instruction.
module y86_prefetch_fetch #(
  parameter int                ADDR_W      = 64,
  parameter int                FETCH_BYTES = 4,
  parameter int                BUF_BYTES   = 16,
  parameter int                IMEM_SIZE   = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     redirect_i,
  input  logic [ADDR_W-1:0]        redirect_pc_i,
  output logic                     imem_req_o,
  output logic [ADDR_W-1:0]        imem_addr_o,
  input  logic                     imem_ack_i,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata_i,
  output logic                     ins_valid_o,
  input  logic                     ins_ready_i,
  output logic [3:0]               icode_o,
  output logic [3:0]               ifunc_o,
  output logic [3:0]               rA_o,
  output logic [3:0]               rB_o,
  output logic [63:0]              valC_o,
  output logic [ADDR_W-1:0]        pc_o,
  output logic [ADDR_W-1:0]        valP_o,
  output logic                     instr_valid_o,
  output logic                     imem_error_o
);

  localparam int PW = $clog2(BUF_BYTES);
  localparam int CW = PW + 1;
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] ERR_HALT = 1'b1;
  // One extra bit so pc + len never wraps when compared against memory size.
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(IMEM_SIZE);

  logic [BUF_BYTES-1:0][7:0] byte_q;
  logic [PW-1:0]             head_q;
  logic [CW-1:0]             count_q;
  logic [ADDR_W-1:0]         pc_q;
  logic [ADDR_W-1:0]         fetch_pc_q;
  logic [0:0]                mode_q;

  logic [9:0][7:0] win;
  logic [3:0]      icode;
  logic            need_regids;
  logic            need_valc;
  logic [3:0]      len;
  logic [ADDR_W:0] end_ext;
  logic            err;
  logic            avail;
  logic            ack;
  logic            fire;
  logic            adv;
  logic [PW-1:0]   tail;

  // Ten-byte view starting at the head; positions at or past count read 0.
  for (genvar i = 0; i < 10; i++) begin : g_win
    logic [PW-1:0] idx;
    assign idx    = head_q + PW'(i);
    assign win[i] = (count_q > CW'(i)) ? byte_q[idx] : 8'h00;
  end

  assign icode = win[0][7:4];

  // Length decode from the head opcode; invalid icodes fall through as len 1.
  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      4'h7, 4'h8: need_valc = 1'b1;
      default: ;
    endcase
  end

  assign len     = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
  assign end_ext = {1'b0, pc_q} + (ADDR_W+1)'(len);
  assign err     = ({1'b0, pc_q} >= MEM_LIM) | ((count_q != '0) & (end_ext > MEM_LIM));
  assign avail   = (count_q != '0) & (count_q >= CW'(len));

  // Reset gating keeps both handshakes quiet while rst_n_i is low.
  assign ins_valid_o = rst_n_i & ~redirect_i & (mode_q == RUN) & (avail | err);
  assign imem_req_o  = rst_n_i & ~redirect_i & (mode_q == RUN)
                     & ({1'b0, fetch_pc_q} < MEM_LIM)
                     & (({1'b0, count_q} + (CW+1)'(FETCH_BYTES)) <= (CW+1)'(BUF_BYTES));
  assign imem_addr_o = fetch_pc_q;

  assign icode_o       = icode;
  assign ifunc_o       = win[0][3:0];
  assign rA_o          = need_regids ? win[1][7:4] : 4'hF;
  assign rB_o          = need_regids ? win[1][3:0] : 4'hF;
  assign valC_o        = !need_valc ? 64'd0 : (need_regids ? win[9:2] : win[8:1]);
  assign pc_o          = pc_q;
  assign valP_o        = pc_q + ADDR_W'(len);
  assign instr_valid_o = (icode <= 4'hB);
  assign imem_error_o  = err;

  assign ack  = imem_req_o & imem_ack_i;
  assign fire = ins_valid_o & ins_ready_i;
  assign adv  = fire & ~err;
  // Room is guaranteed by the request rule, so the tail never hits live bytes.
  assign tail = head_q + count_q[PW-1:0];

  // Byte storage: append each acked beat at the tail.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      byte_q <= '0;
    end else if (!redirect_i && ack) begin
      for (int j = 0; j < FETCH_BYTES; j++)
        byte_q[tail + PW'(j)] <= imem_rdata_i[8*j +: 8];
    end
  end

  // Pointers, PCs and mode; redirect overrides any ack or fire in the cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q     <= '0;
      count_q    <= '0;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      mode_q     <= RUN;
    end else if (redirect_i) begin
      head_q     <= '0;
      count_q    <= '0;
      pc_q       <= redirect_pc_i;
      fetch_pc_q <= redirect_pc_i;
      mode_q     <= RUN;
    end else begin
      if (ack)
        fetch_pc_q <= fetch_pc_q + ADDR_W'(FETCH_BYTES);
      if (adv) begin
        head_q <= head_q + PW'(len);
        pc_q   <= valP_o;
      end
      if (fire && err)
        mode_q <= ERR_HALT;
      count_q <= count_q + (ack ? CW'(FETCH_BYTES) : '0) - (adv ? CW'(len) : '0);
    end
  end

endmodule

// File: doc/y86_prefetch_fetch.md
# y86_prefetch_fetch

Parametrised, sequential successor to the single-cycle Y86-64 fetch stage. It fetches instruction bytes from an external instruction memory over a req/ack handshake, FETCH_BYTES per beat, into a byte prefetch buffer. It delineates variable-length Y86 instructions (1, 2, 9 or 10 bytes) and presents decoded fields to decode over a valid/ready handshake. It sits between the instruction memory port and the decode stage, and supports PC redirect/flush and a memory-bounds halt.

## Interface
- ADDR_W, 64, PC and memory address width.
- FETCH_BYTES, 4, bytes returned per memory beat; one of 2, 4, 8.
- BUF_BYTES, 16, prefetch buffer depth in bytes; power of 2, ≥ 10 + FETCH_BYTES.
- IMEM_SIZE, 1024, instruction memory size in bytes; an address ≥ IMEM_SIZE is out of range.
- RESET_PC, 0, PC loaded by reset.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- redirect_i  in  1  flush the buffer and restart fetch at redirect_pc_i.
- redirect_pc_i  in  ADDR_W  new PC.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_W  byte address of the first requested byte; unaligned is allowed.
- imem_ack_i  in  1  request accepted; imem_rdata_i is valid in the same cycle.
- imem_rdata_i  in  8*FETCH_BYTES  bytes addr..addr+FETCH_BYTES-1, with byte 0 in [7:0].
- ins_valid_o  out  1  instruction presented.
- ins_ready_i  in  1  decode accepts. A fire is ins_valid_o & ins_ready_i.
- icode_o, ifunc_o, rA_o, rB_o  out  4 each  instruction fields.
- valC_o  out  64  little-endian constant.
- pc_o  out  ADDR_W  PC of the presented instruction.
- valP_o  out  ADDR_W  pc_o + len.
- instr_valid_o  out  1  icode ≤ 0xB.
- imem_error_o  out  1  the presented instruction lies outside memory.

## Operation
- State registers: byte buffer (circular, head pointer), count (0..BUF_BYTES), pc (head address), fetch_pc (next byte to request), mode ∈ {RUN, ERR_HALT}.
- Request rule: imem_req_o = (mode==RUN) & !redirect_i & (fetch_pc < IMEM_SIZE) & (count + FETCH_BYTES ≤ BUF_BYTES).
  - imem_addr_o = fetch_pc.
  - When the request is acked, the FETCH_BYTES bytes are appended and fetch_pc advances by FETCH_BYTES.
- Length decode from the head byte:
  - need_regids = icode ∈ {2,3,4,5,6,A,B}.
  - need_valC = icode ∈ {3,4,5,7,8}. MRMOVQ (5) is included.
  - len = 1 + need_regids + 8·need_valC. An invalid icode (C–F) gives len = 1.
- Field extraction:
  - icode/ifunc come from byte 0.
  - rA/rB come from byte 1 when need_regids, otherwise 0xF each.
  - valC comes from bytes 1..8 when !need_regids, otherwise bytes 2..9. It is 0 when !need_valC.
- Error rule: err = (pc ≥ IMEM_SIZE) | (count ≥ 1 & pc + len > IMEM_SIZE).
- Presentation:
  - ins_valid_o = !redirect_i & (mode==RUN) & ((count ≥ 1 & count ≥ len) | err).
  - imem_error_o = err.
  - Byte positions at or beyond count read as 0. This covers pc ≥ IMEM_SIZE with count = 0, which presents icode 0.
- On fire:
  - Without err: count -= len, pc += len, head advances by len.
  - With err: mode goes to ERR_HALT. There are no further requests or outputs until redirect.
- An ack and a fire in the same cycle are both applied: count' = count + FETCH_BYTES − len.
- Redirect has priority over everything:
  - count = 0, pc = fetch_pc = redirect_pc_i, mode = RUN.
  - An ack in the same cycle is discarded.
  - ins_valid_o is forced 0, so no fire can occur.
- An invalid icode is passed through with instr_valid_o = 0, len = 1, and no halt. Halting on HLT or invalid icode is the consumer's job.

## Timing
- Reset values: count 0, pc = fetch_pc = RESET_PC, mode RUN, buffer bytes 0.
- Output values during reset: imem_req_o 0, ins_valid_o 0, icode/ifunc 0, rA/rB 0xF, valC_o 0, pc_o RESET_PC.
- Reset asserted mid-transfer abandons the transfer. The memory must tolerate the dropped request.
- imem_req_o, imem_addr_o and all ins_* outputs are combinational from registered state. The only combinational paths from inputs are the redirect_i gating of ins_valid_o and imem_req_o.
- Latency:
  - Data acked in cycle t is visible to presentation in cycle t+1.
  - Redirect in cycle t → request in t+1 → earliest ins_valid_o in t+2 if len ≤ FETCH_BYTES and the ack comes in t+1.
- Throughput: one instruction per cycle while the buffer holds ≥ len bytes.
- Once asserted, ins_valid_o and the fields hold stable until fire or redirect.

## Test plan
- Reset, then the memory holds 30 f8 08 00 00 00 00 00 00 00 at address 0 and acks every cycle (FETCH_BYTES=4), with ready always high.
  - Expect 3 beats, then in the cycle after the 3rd ack: icode 3, rA F, rB 8, valC 8, pc 0, valP 10.
- Back-to-back 63 00, 62 66, 10 at address 20 with ready held low until the buffer fills.
  - Expect requests to stop at count 16.
  - Then, with ready high: three fires on consecutive cycles with valP 22, 24, 25.
- Byte 50 03 followed by 8 bytes 0x10 (MRMOVQ).
  - Expect len 10, rA 0, rB 3, valC 0x1010101010101010, valP pc+10.
- Redirect to 0x40 in the same cycle as an ack and with ins_valid_o high.
  - Expect no fire, the ack data discarded, count 0, and the next imem_addr_o of 0x40.
- Redirect to 1020 with 30 f2 … in memory.
  - Expect ins_valid_o with imem_error_o 1, pc 1020.
  - After fire: no more requests and ins_valid_o stays 0 until the next redirect.
- Icode 0xD byte followed by 10.
  - Expect an output with instr_valid_o 0 and valP pc+1.
  - Then the NOP, with instr_valid_o 1.
